// File: rtl/wb_stack.sv
// Forth-style data/return stack file written back from the EX/WB register.
// Optional sticky overflow/underflow flags are built when WB_STACK_ERR_EN is defined.
module wb_stack #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  dsp_n_i,
  input  logic [7:0]  rsp_n_i,
  input  logic        dsk_wen_i,
  input  logic        rsk_wen_i,
  input  logic [15:0] dsk_data_i,
  input  logic [15:0] rsk_data_i,
  input  logic        hold_flag_i,
  input  logic        err_clr_i,
  output logic [7:0]  dsp_o,
  output logic [7:0]  rsp_o,
  output logic [15:0] dst_o,
  output logic [15:0] dsn_o,
  output logic [15:0] rst_o,
  output logic        dsk_ovf_o,
  output logic        dsk_unf_o,
  output logic        rsk_ovf_o,
  output logic        rsk_unf_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]   r_dmem [DEPTH];
  logic [15:0]   r_rmem [DEPTH];
  logic [7:0]    r_dsp;
  logic [7:0]    r_rsp;
  logic          w_commit;
  logic [AW-1:0] w_dsn_idx;

  assign w_commit = ~hold_flag_i;

  // Pointers and both arrays; the write index wraps to the low pointer bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dsp <= '0;
      r_rsp <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_dmem[i] <= '0;
        r_rmem[i] <= '0;
      end
    end else if (w_commit) begin
      r_dsp <= dsp_n_i;
      r_rsp <= rsp_n_i;
      if (dsk_wen_i) r_dmem[dsp_n_i[AW-1:0]] <= dsk_data_i;
      if (rsk_wen_i) r_rmem[rsp_n_i[AW-1:0]] <= rsk_data_i;
    end
  end

  assign w_dsn_idx = r_dsp[AW-1:0] - AW'(1);

  assign dsp_o = r_dsp;
  assign rsp_o = r_rsp;
  assign dst_o = r_dmem[r_dsp[AW-1:0]];
  assign dsn_o = r_dmem[w_dsn_idx];
  assign rst_o = r_rmem[r_rsp[AW-1:0]];

`ifdef WB_STACK_ERR_EN
  logic r_dsk_ovf, r_dsk_unf, r_rsk_ovf, r_rsk_unf;
  logic w_dsk_ovf_set, w_dsk_unf_set, w_rsk_ovf_set, w_rsk_unf_set;

  // Bit 7 set means the pointer went below zero; otherwise >= DEPTH is overflow.
  assign w_dsk_unf_set = w_commit & dsp_n_i[7];
  assign w_rsk_unf_set = w_commit & rsp_n_i[7];
  assign w_dsk_ovf_set = w_commit & ~dsp_n_i[7] & (dsp_n_i >= 8'(DEPTH));
  assign w_rsk_ovf_set = w_commit & ~rsp_n_i[7] & (rsp_n_i >= 8'(DEPTH));

  // Sticky flags; a new error beats a same-edge clear, and clear works during hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dsk_ovf <= 1'b0;
      r_dsk_unf <= 1'b0;
      r_rsk_ovf <= 1'b0;
      r_rsk_unf <= 1'b0;
    end else begin
      r_dsk_ovf <= w_dsk_ovf_set | (r_dsk_ovf & ~err_clr_i);
      r_dsk_unf <= w_dsk_unf_set | (r_dsk_unf & ~err_clr_i);
      r_rsk_ovf <= w_rsk_ovf_set | (r_rsk_ovf & ~err_clr_i);
      r_rsk_unf <= w_rsk_unf_set | (r_rsk_unf & ~err_clr_i);
    end
  end

  assign dsk_ovf_o = r_dsk_ovf;
  assign dsk_unf_o = r_dsk_unf;
  assign rsk_ovf_o = r_rsk_ovf;
  assign rsk_unf_o = r_rsk_unf;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr_i;
  assign dsk_ovf_o = 1'b0;
  assign dsk_unf_o = 1'b0;
  assign rsk_ovf_o = 1'b0;
  assign rsk_unf_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stack.sv
// Self-checking bench for wb_stack: directed vector table, corner sequences,
// and randomized traffic against an array-based reference model.
module tb_wb_stack;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  dsp_n_i = '0, rsp_n_i = '0;
  logic        dsk_wen_i = 1'b0, rsk_wen_i = 1'b0;
  logic [15:0] dsk_data_i = '0, rsk_data_i = '0;
  logic        hold_flag_i = 1'b0, err_clr_i = 1'b0;
  logic [7:0]  dsp_o, rsp_o;
  logic [15:0] dst_o, dsn_o, rst_o;
  logic        dsk_ovf_o, dsk_unf_o, rsk_ovf_o, rsk_unf_o;

  wb_stack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .dsp_n_i(dsp_n_i), .rsp_n_i(rsp_n_i),
    .dsk_wen_i(dsk_wen_i), .rsk_wen_i(rsk_wen_i),
    .dsk_data_i(dsk_data_i), .rsk_data_i(rsk_data_i),
    .hold_flag_i(hold_flag_i), .err_clr_i(err_clr_i),
    .dsp_o(dsp_o), .rsp_o(rsp_o),
    .dst_o(dst_o), .dsn_o(dsn_o), .rst_o(rst_o),
    .dsk_ovf_o(dsk_ovf_o), .dsk_unf_o(dsk_unf_o),
    .rsk_ovf_o(rsk_ovf_o), .rsk_unf_o(rsk_unf_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain arrays and integer pointers
  logic [15:0] md [DEPTH];
  logic [15:0] mr [DEPTH];
  int          mdsp, mrsp;
  bit          f_dovf, f_dunf, f_rovf, f_runf;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin md[i] = '0; mr[i] = '0; end
    mdsp = 0; mrsp = 0;
    f_dovf = 0; f_dunf = 0; f_rovf = 0; f_runf = 0;
  endtask

  task automatic model_edge();
    bit c, du, dov, ru, rov;
    int dn, rn;
    c  = !hold_flag_i;
    dn = int'(dsp_n_i);
    rn = int'(rsp_n_i);
    du  = c && dn >= 128;
    dov = c && dn < 128 && dn >= DEPTH;
    ru  = c && rn >= 128;
    rov = c && rn < 128 && rn >= DEPTH;
    if (c) begin
      if (dsk_wen_i) md[dn % DEPTH] = dsk_data_i;
      if (rsk_wen_i) mr[rn % DEPTH] = rsk_data_i;
      mdsp = dn;
      mrsp = rn;
    end
`ifdef WB_STACK_ERR_EN
    f_dunf = du  || (f_dunf && !err_clr_i);
    f_dovf = dov || (f_dovf && !err_clr_i);
    f_runf = ru  || (f_runf && !err_clr_i);
    f_rovf = rov || (f_rovf && !err_clr_i);
`else
    if (du || dov || ru || rov) begin f_dunf = 0; f_dovf = 0; f_runf = 0; f_rovf = 0; end
`endif
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".dsp"}, 16'(dsp_o), 16'(mdsp));
    chk({tag, ".rsp"}, 16'(rsp_o), 16'(mrsp));
    chk({tag, ".dst"}, dst_o, md[mdsp % DEPTH]);
    chk({tag, ".dsn"}, dsn_o, md[(mdsp + DEPTH - 1) % DEPTH]);
    chk({tag, ".rst"}, rst_o, mr[mrsp % DEPTH]);
    chk({tag, ".dovf"}, 16'(dsk_ovf_o), 16'(f_dovf));
    chk({tag, ".dunf"}, 16'(dsk_unf_o), 16'(f_dunf));
    chk({tag, ".rovf"}, 16'(rsk_ovf_o), 16'(f_rovf));
    chk({tag, ".runf"}, 16'(rsk_unf_o), 16'(f_runf));
  endtask

  // One clock edge with the model tracking it; sample 1 time unit later
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    err_clr_i = 1'b0;
  endtask

  task automatic drive(input logic hold, input logic clr,
                       input logic [7:0] dn, input logic dw, input logic [15:0] dd,
                       input logic [7:0] rn, input logic rw, input logic [15:0] rd);
    hold_flag_i = hold; err_clr_i = clr;
    dsp_n_i = dn; dsk_wen_i = dw; dsk_data_i = dd;
    rsp_n_i = rn; rsk_wen_i = rw; rsk_data_i = rd;
  endtask

  typedef struct {
    logic        hold;
    logic [7:0]  dn;
    logic        dw;
    logic [15:0] dd;
    logic [7:0]  rn;
    logic        rw;
    logic [15:0] rd;
    logic [7:0]  e_dsp;
    logic [15:0] e_dst;
    logic [15:0] e_dsn;
    logic [7:0]  e_rsp;
    logic [15:0] e_rst;
  } vec_t;

  vec_t tbl [9];

  bit exp_err_set;

  initial begin
`ifdef WB_STACK_ERR_EN
    exp_err_set = 1;
`else
    exp_err_set = 0;
`endif
    tbl[0] = '{0, 8'd1,  1, 16'hA5A5, 8'd0, 0, 16'h0000, 8'd1,  16'hA5A5, 16'h0000, 8'd0, 16'h0000};
    tbl[1] = '{0, 8'd1,  1, 16'h1111, 8'd0, 0, 16'h0000, 8'd1,  16'h1111, 16'h0000, 8'd0, 16'h0000};
    tbl[2] = '{0, 8'd2,  1, 16'h2222, 8'd0, 0, 16'h0000, 8'd2,  16'h2222, 16'h1111, 8'd0, 16'h0000};
    tbl[3] = '{0, 8'd1,  0, 16'h9999, 8'd0, 0, 16'h0000, 8'd1,  16'h1111, 16'h0000, 8'd0, 16'h0000};
    tbl[4] = '{1, 8'd5,  1, 16'hBEEF, 8'd7, 1, 16'h4444, 8'd1,  16'h1111, 16'h0000, 8'd0, 16'h0000};
    tbl[5] = '{0, 8'd5,  1, 16'hBEEF, 8'd0, 0, 16'h0000, 8'd5,  16'hBEEF, 16'h0000, 8'd0, 16'h0000};
    tbl[6] = '{0, 8'd5,  0, 16'h0000, 8'd3, 1, 16'h7777, 8'd5,  16'hBEEF, 16'h0000, 8'd3, 16'h7777};
    tbl[7] = '{0, 8'd15, 1, 16'h0F0F, 8'd3, 0, 16'h0000, 8'd15, 16'h0F0F, 16'h0000, 8'd3, 16'h7777};
    tbl[8] = '{0, 8'd0,  0, 16'h0000, 8'd3, 0, 16'h0000, 8'd0,  16'h0000, 16'h0F0F, 8'd3, 16'h7777};

    // Reset state, with a write pending on the inputs
    model_reset();
    dsk_wen_i = 1'b1; dsp_n_i = 8'd3; dsk_data_i = 16'hDEAD;
    #12;
    chk_model("reset");
    chk("reset.dst_const", dst_o, 16'h0000);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].hold, 0, tbl[i].dn, tbl[i].dw, tbl[i].dd, tbl[i].rn, tbl[i].rw, tbl[i].rd);
      step();
      chk($sformatf("tbl%0d.dsp", i), 16'(dsp_o), 16'(tbl[i].e_dsp));
      chk($sformatf("tbl%0d.dst", i), dst_o, tbl[i].e_dst);
      chk($sformatf("tbl%0d.dsn", i), dsn_o, tbl[i].e_dsn);
      chk($sformatf("tbl%0d.rsp", i), 16'(rsp_o), 16'(tbl[i].e_rsp));
      chk($sformatf("tbl%0d.rst", i), rst_o, tbl[i].e_rst);
      chk($sformatf("tbl%0d.flags", i), 16'({dsk_ovf_o, dsk_unf_o, rsk_ovf_o, rsk_unf_o}), 16'h0);
    end

    // Data underflow from dsp=0, then clear while held
    drive(0, 0, 8'hFF, 0, 16'h0, 8'd3, 0, 16'h0);
    step();
    chk("unf.dsp", 16'(dsp_o), 16'h00FF);
    chk("unf.dst", dst_o, 16'h0F0F);
    chk("unf.flag", 16'(dsk_unf_o), 16'(exp_err_set));
    chk("unf.ovf_clear", 16'(dsk_ovf_o), 16'h0);
    drive(1, 1, 8'h00, 1, 16'h5555, 8'd0, 0, 16'h0);
    step();
    chk("unf.clr_flag", 16'(dsk_unf_o), 16'h0);
    chk("unf.clr_hold_dsp", 16'(dsp_o), 16'h00FF);

    // Return overflow lands at wrapped index; same-edge clear+error keeps flag set
    drive(0, 0, 8'h00, 0, 16'h0, 8'd16, 1, 16'h0C0C);
    step();
    chk("ovf.flag", 16'(rsk_ovf_o), 16'(exp_err_set));
    chk("ovf.rsp", 16'(rsp_o), 16'd16);
    chk("ovf.rst", rst_o, 16'h0C0C);
    drive(0, 1, 8'h00, 0, 16'h0, 8'd17, 0, 16'h0);
    step();
    chk("ovf.set_wins", 16'(rsk_ovf_o), 16'(exp_err_set));
    chk("ovf.rst_idx1", rst_o, 16'h0000);
    chk_model("ovf");
    drive(0, 1, 8'h00, 0, 16'h0, 8'd0, 0, 16'h0);
    step();
    chk_model("clr_all");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [7:0] dn, rn;
      if ($urandom_range(0, 9) < 7) dn = 8'(mdsp + int'($urandom_range(0, 2)) - 1);
      else                          dn = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 7) rn = 8'(mrsp + int'($urandom_range(0, 2)) - 1);
      else                          rn = 8'($urandom_range(0, 255));
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            dn, 1'($urandom_range(0, 1)), 16'($urandom),
            rn, 1'($urandom_range(0, 1)), 16'($urandom));
      step();
      if (n % 8 == 0) chk_model($sformatf("rnd%0d", n));
      else begin
        chk($sformatf("rnd%0d.dst", n), dst_o, md[mdsp % DEPTH]);
        chk($sformatf("rnd%0d.dsn", n), dsn_o, md[(mdsp + DEPTH - 1) % DEPTH]);
        chk($sformatf("rnd%0d.rst", n), rst_o, mr[mrsp % DEPTH]);
      end
    end

    // Three pushes, then asynchronous reset with no clock edge
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 8'(i), 1, 16'(16'h1000 + i), 8'(i), 1, 16'(16'h2000 + i));
      step();
    end
    chk("push3.dst", dst_o, 16'h1003);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_model("async_rst");
    drive(0, 0, 8'd2, 1, 16'hFACE, 8'd2, 1, 16'hCAFE);
    @(posedge clk);
    #1;
    chk_model("rst_held_edge");
    #2;
    rst_n = 1'b1;
    drive(0, 0, 8'd1, 1, 16'h3333, 8'd0, 0, 16'h0);
    step();
    chk("post_rst.dsp", 16'(dsp_o), 16'd1);
    chk("post_rst.dst", dst_o, 16'h3333);
    chk_model("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
